// File: rtl/pipe_catch_buffer.sv
// pipe_catch_buffer
// Receive-side terminator for a fixed-latency, credit-controlled data pipe.
// Items issued upstream reserve a FIFO slot. The slot is held from issue
// until the item is popped downstream, so an arrival never finds the FIFO
// full under legal use and the pipe itself needs no backpressure.
// All outputs come from registered state only. No output has a
// combinational path from ISSUE, IN_VLD or OUT_RDY.

module pipe_catch_buffer #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          ISSUE,
    output logic          CREDIT_OK,
    input  logic          IN_VLD,
    input  logic [W-1:0]  IN_DATA,
    output logic          OUT_VLD,
    input  logic          OUT_RDY,
    output logic [W-1:0]  OUT_DATA,
    output logic [CW-1:0] COUNT,
    output logic          ERR
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    // Storage. It is never reset; contents only matter while occupancy covers them.
    logic [W-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] occ_reg,    occ_next;
    logic [CW-1:0] res_reg,    res_next;
    logic          err_reg,    err_next;

    logic full;
    logic iss;
    logic pop;
    logic push;
    logic no_reservation;

    // Outputs are decoded from registered state only.
    assign CREDIT_OK = (res_reg < DEPTH_C);
    assign OUT_VLD   = (occ_reg != '0);
    assign OUT_DATA  = mem[rd_ptr_reg];
    assign COUNT     = occ_reg;
    assign ERR       = err_reg;

    assign full           = (occ_reg == DEPTH_C);
    assign iss            = ISSUE & CREDIT_OK;
    assign pop            = OUT_VLD & OUT_RDY;
    // When full, an arrival may still land in the slot a same-cycle pop frees.
    assign push           = IN_VLD & (~full | pop);
    assign no_reservation = (res_reg == occ_reg);

    // Next-state logic: pointers, occupancy, reservations and the error flag.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        occ_next    = occ_reg;
        res_next    = res_reg;
        err_next    = err_reg;

        // Pointers wrap explicitly, so DEPTH need not be a power of two.
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_P) ? '0 : wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_P) ? '0 : rd_ptr_reg + PW'(1);
        end

        case ({push, pop})
            2'b10:   occ_next = occ_reg + CW'(1);
            2'b01:   occ_next = occ_reg - CW'(1);
            default: occ_next = occ_reg;
        endcase

        // A credit is held from issue until the item leaves downstream.
        // Decrementing stops at zero. Under legal use res >= occ, so zero is
        // never reached here. The floor only keeps res inside its range after
        // an unreserved arrival has already been flagged.
        case ({iss, pop})
            2'b10:   res_next = res_reg + CW'(1);
            2'b01:   res_next = (res_reg == '0) ? '0 : res_reg - CW'(1);
            default: res_next = res_reg;
        endcase

        // Sticky flag for: an issue without credit, an overflowing arrival,
        // or an arrival with no outstanding reservation.
        if ((ISSUE & ~CREDIT_OK) | (IN_VLD & full & ~pop) | (IN_VLD & no_reservation)) begin
            err_next = 1'b1;
        end
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
            res_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            occ_reg    <= occ_next;
            res_reg    <= res_next;
            err_reg    <= err_next;
        end
    end

    // FIFO write port. An item written here is visible at the head one cycle later.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= IN_DATA;
        end
    end

endmodule

// File: tb/tb_pipe_catch_buffer.sv
// Bench for pipe_catch_buffer with DEPTH=4 and W=8.
// It has a vector table for fill and drain, plus directed sequences for
// streaming, the full bypass case, the error cases and a mid-stream reset.
// Inputs change on the falling edge. Outputs are checked on the falling edge
// before that cycle's inputs are applied.

module tb_pipe_catch_buffer;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK;
    logic          RSTN;
    logic          ISSUE;
    logic          CREDIT_OK;
    logic          IN_VLD;
    logic [W-1:0]  IN_DATA;
    logic          OUT_VLD;
    logic          OUT_RDY;
    logic [W-1:0]  OUT_DATA;
    logic [CW-1:0] COUNT;
    logic          ERR;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       issue;
        logic       in_vld;
        logic [7:0] in_data;
        logic       out_rdy;
        logic       e_cr;
        logic       e_vld;
        logic [7:0] e_data;
        int         e_cnt;
        logic       e_err;
        logic       chk_d;
    } vec_t;

    vec_t vq[$];

    pipe_catch_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .ISSUE     (ISSUE),
        .CREDIT_OK (CREDIT_OK),
        .IN_VLD    (IN_VLD),
        .IN_DATA   (IN_DATA),
        .OUT_VLD   (OUT_VLD),
        .OUT_RDY   (OUT_RDY),
        .OUT_DATA  (OUT_DATA),
        .COUNT     (COUNT),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle, starting and ending on a falling edge.
    task automatic step(input logic iss, input logic iv, input logic [7:0] d, input logic rdy);
        ISSUE   = iss;
        IN_VLD  = iv;
        IN_DATA = d;
        OUT_RDY = rdy;
        @(posedge CLK);
        @(negedge CLK);
        ISSUE   = 1'b0;
        IN_VLD  = 1'b0;
        OUT_RDY = 1'b0;
    endtask

    task automatic do_reset();
        ISSUE   = 1'b0;
        IN_VLD  = 1'b0;
        IN_DATA = '0;
        OUT_RDY = 1'b0;
        #1 RSTN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " credit"}, int'(CREDIT_OK), 1);
        chk({tag, " out_vld"}, int'(OUT_VLD), 0);
        chk({tag, " count"}, int'(COUNT), 0);
        chk({tag, " err"}, int'(ERR), 0);
    endtask

    // Issue 4 items, then deliver 4 legal arrivals base+0 .. base+3.
    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, base + 8'(i), 1'b0);
    endtask

    task automatic drain_chk(input string tag, input logic [7:0] exp);
        chk({tag, " out_vld"}, int'(OUT_VLD), 1);
        chk({tag, " data"}, int'(OUT_DATA), int'(exp));
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic add(input logic iss, input logic iv, input logic [7:0] d, input logic rdy,
                       input logic cr, input logic vld, input logic [7:0] ed, input int cnt,
                       input logic er, input logic dchk);
        vec_t v;
        v.issue = iss; v.in_vld = iv; v.in_data = d; v.out_rdy = rdy;
        v.e_cr = cr; v.e_vld = vld; v.e_data = ed; v.e_cnt = cnt;
        v.e_err = er; v.chk_d = dchk;
        vq.push_back(v);
    endtask

    initial begin
        int          pop_idx;
        int          n_stream;
        logic [7:0]  exp_d;
        vec_t        v;

        RSTN    = 1'b0;
        ISSUE   = 1'b0;
        IN_VLD  = 1'b0;
        IN_DATA = '0;
        OUT_RDY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;

        // Expected values are for the state at the start of each cycle;
        // the inputs are the ones applied during that cycle.
        //   iss iv  data   rdy  cr  vld  edata  cnt err dchk
        for (int i = 0; i < 5; i++)
            add(0, 0, 8'h00, 0,  1,  0,  8'h00, 0,  0,  0);  // idle after reset
        add(1, 0, 8'h00, 0,  1,  0,  8'h00, 0,  0,  0);      // issue 1
        add(1, 0, 8'h00, 0,  1,  0,  8'h00, 0,  0,  0);      // issue 2
        add(1, 0, 8'h00, 0,  1,  0,  8'h00, 0,  0,  0);      // issue 3
        add(1, 1, 8'h11, 0,  1,  0,  8'h00, 0,  0,  0);      // issue 4, arrival 0x11
        add(0, 1, 8'h22, 0,  0,  1,  8'h11, 1,  0,  1);      // credits exhausted
        add(0, 1, 8'h33, 0,  0,  1,  8'h11, 2,  0,  1);
        add(0, 1, 8'h44, 0,  0,  1,  8'h11, 3,  0,  1);
        add(0, 0, 8'h00, 0,  0,  1,  8'h11, 4,  0,  1);      // full
        add(0, 0, 8'h00, 1,  0,  1,  8'h11, 4,  0,  1);      // pop 0x11
        add(0, 0, 8'h00, 1,  1,  1,  8'h22, 3,  0,  1);      // credit back
        add(0, 0, 8'h00, 1,  1,  1,  8'h33, 2,  0,  1);
        add(0, 0, 8'h00, 1,  1,  1,  8'h44, 1,  0,  1);
        add(0, 0, 8'h00, 0,  1,  0,  8'h00, 0,  0,  0);      // drained

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            chk($sformatf("vec%0d credit", i), int'(CREDIT_OK), int'(v.e_cr));
            chk($sformatf("vec%0d out_vld", i), int'(OUT_VLD), int'(v.e_vld));
            chk($sformatf("vec%0d count", i), int'(COUNT), v.e_cnt);
            chk($sformatf("vec%0d err", i), int'(ERR), int'(v.e_err));
            if (v.chk_d) chk($sformatf("vec%0d data", i), int'(OUT_DATA), int'(v.e_data));
            step(v.issue, v.in_vld, v.in_data, v.out_rdy);
        end

        // Streaming: issue every cycle, arrivals 2 cycles later, consumer always ready.
        do_reset();
        chk_reset_state("stream_rst");
        n_stream = 48;
        pop_idx  = 0;
        for (int k = 0; k < n_stream + 6; k++) begin
            if (k < n_stream) chk($sformatf("stream%0d credit", k), int'(CREDIT_OK), 1);
            if (OUT_VLD) begin
                exp_d = 8'((pop_idx * 7 + 3) & 8'hFF);
                chk($sformatf("stream pop%0d data", pop_idx), int'(OUT_DATA), int'(exp_d));
                pop_idx++;
            end
            ISSUE   = (k < n_stream);
            IN_VLD  = (k >= 2) && (k - 2 < n_stream);
            IN_DATA = 8'(((k - 2) * 7 + 3) & 8'hFF);
            OUT_RDY = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
        end
        ISSUE = 1'b0; IN_VLD = 1'b0; OUT_RDY = 1'b0;
        chk("stream pops", pop_idx, n_stream);
        chk("stream err", int'(ERR), 0);
        chk("stream count", int'(COUNT), 0);

        // Full with a simultaneous pop and arrival. The arrival has no
        // reservation, so it also raises the sticky flag.
        do_reset();
        fill(8'hA1);
        chk("bypass pre count", int'(COUNT), 4);
        chk("bypass pre err", int'(ERR), 0);
        chk("bypass pre data", int'(OUT_DATA), 8'hA1);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("bypass count", int'(COUNT), 4);
        chk("bypass err", int'(ERR), 1);
        drain_chk("bypass d0", 8'hA2);
        drain_chk("bypass d1", 8'hA3);
        drain_chk("bypass d2", 8'hA4);
        drain_chk("bypass d3", 8'h55);
        chk("bypass end count", int'(COUNT), 0);

        // Issue without credit: flagged and ignored.
        do_reset();
        chk_reset_state("erra_rst");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("erra credit0", int'(CREDIT_OK), 0);
        chk("erra err pre", int'(ERR), 0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("erra err", int'(ERR), 1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'hB1 + 8'(i), 1'b0);
        chk("erra count", int'(COUNT), 4);
        chk("erra credit full", int'(CREDIT_OK), 0);
        drain_chk("erra d0", 8'hB1);
        chk("erra credit back", int'(CREDIT_OK), 1);
        drain_chk("erra d1", 8'hB2);
        drain_chk("erra d2", 8'hB3);
        drain_chk("erra d3", 8'hB4);
        chk("erra err sticky", int'(ERR), 1);

        // Arrival while full with no pop: dropped, contents intact.
        do_reset();
        chk_reset_state("errb_rst");
        fill(8'hC1);
        chk("errb err pre", int'(ERR), 0);
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        chk("errb err", int'(ERR), 1);
        chk("errb count", int'(COUNT), 4);
        drain_chk("errb d0", 8'hC1);
        drain_chk("errb d1", 8'hC2);
        drain_chk("errb d2", 8'hC3);
        drain_chk("errb d3", 8'hC4);
        chk("errb end count", int'(COUNT), 0);
        chk("errb err sticky", int'(ERR), 1);

        // Reset pulse mid-stream clears reservations and occupancy.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0);
        chk("mid pre out_vld", int'(OUT_VLD), 1);
        #1 RSTN = 1'b0;
        #1;
        chk_reset_state("mid_async");
        @(negedge CLK);
        RSTN = 1'b1;
        chk_reset_state("mid_rel");
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid credit after 3", int'(CREDIT_OK), 1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid credit after 4", int'(CREDIT_OK), 0);
        chk("mid count", int'(COUNT), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
